// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter and access sequencer for the single-port
//                data memory. Shares the memory between the CPU datapath
//                (cpu_*) and an external requester (ext_*), running every
//                access as IDLE -> ISSUE -> [WAIT] -> RESP and returning a
//                one-cycle acknowledge to the winning port.
//
//  Ports       : clk                  - clock, rising edge
//                reset                - asynchronous reset, active low
//                cpu_req/we/addr/wdata - CPU request, held until cpu_ack
//                cpu_ack, cpu_rdata   - CPU completion pulse / read result
//                ext_req/we/addr/wdata - external request, held until ext_ack
//                ext_ack, ext_rdata   - external completion pulse / result
//                mem_addr/data/wren   - memory address, write data, write enable
//                mem_q                - memory read data
//                busy                 - a transaction is in progress
//                grant_ext            - current transaction belongs to ext
//
//  Options     : DMEM_ARB_RR_EN - when defined, ties are resolved
//                round-robin; otherwise cpu has fixed priority.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int reg_width  = 12,
    parameter int addr_width = 12,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [addr_width-1:0] cpu_addr,
    input  logic [reg_width-1:0]  cpu_wdata,
    output logic                  cpu_ack,
    output logic [reg_width-1:0]  cpu_rdata,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [addr_width-1:0] ext_addr,
    input  logic [reg_width-1:0]  ext_wdata,
    output logic                  ext_ack,
    output logic [reg_width-1:0]  ext_rdata,
    output logic [addr_width-1:0] mem_addr,
    output logic [reg_width-1:0]  mem_data,
    output logic                  mem_wren,
    input  logic [reg_width-1:0]  mem_q,
    output logic                  busy,
    output logic                  grant_ext
);

    localparam logic [1:0] c_MEM_LAT = 2'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_we;
    logic [1:0]              r_cnt;
    logic                    w_any_req;
    logic                    w_pick_ext;
    logic                    w_sel_we;
    logic [addr_width-1:0]   w_sel_addr;
    logic [reg_width-1:0]    w_sel_wdata;

    assign w_any_req = cpu_req | ext_req;

`ifdef DMEM_ARB_RR_EN
    // Port served by the most recent grant; ties go to the other one.
    logic r_last_ext;

    assign w_pick_ext = ext_req & (~cpu_req | ~r_last_ext);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_ext <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_ext <= w_pick_ext;
        end
    end
`else
    assign w_pick_ext = ext_req & ~cpu_req;
`endif

    assign w_sel_we    = w_pick_ext ? ext_we    : cpu_we;
    assign w_sel_addr  = w_pick_ext ? ext_addr  : cpu_addr;
    assign w_sel_wdata = w_pick_ext ? ext_wdata : cpu_wdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_ISSUE;
            S_ISSUE: w_next = r_we ? S_RESP : S_WAIT;
            // <= 1 rather than == 1 so a zero count can never lock the FSM
            S_WAIT:  if (r_cnt <= 2'd1) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs. Memory address/data are loaded at grant so they
    // are already valid during ISSUE, then simply hold afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we      <= 1'b0;
            r_cnt     <= 2'd0;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_wren  <= 1'b0;
            cpu_ack   <= 1'b0;
            ext_ack   <= 1'b0;
            cpu_rdata <= '0;
            ext_rdata <= '0;
            busy      <= 1'b0;
            grant_ext <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            cpu_ack  <= 1'b0;
            ext_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        grant_ext <= w_pick_ext;
                        r_we      <= w_sel_we;
                        mem_addr  <= w_sel_addr;
                        mem_data  <= w_sel_wdata;
                        mem_wren  <= w_sel_we;
                        busy      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        cpu_ack <= ~grant_ext;
                        ext_ack <= grant_ext;
                    end else begin
                        r_cnt <= c_MEM_LAT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) begin
                        if (grant_ext) begin
                            ext_rdata <= mem_q;
                        end else begin
                            cpu_rdata <= mem_q;
                        end
                        cpu_ack <= ~grant_ext;
                        ext_ack <= grant_ext;
                    end
                end
                S_RESP: begin
                    busy      <= 1'b0;
                    grant_ext <= 1'b0;
                end
                default: begin
                    busy      <= 1'b0;
                    grant_ext <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
